// File: rtl/load_store_unit_if.sv
// Request/response and byte-memory bundle for load_store_unit.
// Processor side uses master, the unit uses slave, and the data memory uses memory.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );

  modport memory (
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: serialises byte/half/word accesses onto a byte-wide memory,
// big-endian, with alignment/size error detection and load sign extension.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q;
  logic [1:0]        last_q;
  logic [1:0]        size_q;
  logic              write_q;
  logic              signed_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;

  logic              accept;
  logic              bad_req;
  logic              last_byte;
  logic [1:0]        byte_idx;
  logic [31:0]       load_ext;

  assign accept    = bus.req_valid && (state_q == IDLE);
  assign bad_req   = (bus.req_size == 2'b11) ||
                     ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign last_byte = (cnt_q == last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bad_req ? RESP : XFER;
      XFER:    if (last_byte) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      last_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      size_q   <= bus.req_size;
      write_q  <= bus.req_write;
      signed_q <= bus.req_signed;
      err_q    <= bad_req;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
      asm_q    <= '0;
      case (bus.req_size)
        2'b00:   last_q <= 2'd0;
        2'b01:   last_q <= 2'd1;
        default: last_q <= 2'd3;
      endcase
    end else if (state_q == XFER) begin
      cnt_q <= cnt_q + 2'd1;
      // First byte read is the most significant, so shifting left yields big-endian order.
      if (!write_q) asm_q <= {asm_q[23:0], bus.mem_rdata};
    end
  end

  always_comb begin
    load_ext = asm_q;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & asm_q[7]}},  asm_q[7:0]};
      2'b01:   load_ext = {{16{signed_q & asm_q[15]}}, asm_q[15:0]};
      default: load_ext = asm_q;
    endcase
  end

  assign byte_idx       = last_q - cnt_q;
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = ((state_q == RESP) && !err_q && !write_q) ? load_ext : '0;
  assign bus.mem_addr   = (state_q == XFER) ? addr_q + ADDR_W'(cnt_q) : addr_q;
  assign bus.mem_we     = (state_q == XFER) && write_q;
  assign bus.mem_wdata  = bus.mem_we ? wdata_q[{byte_idx, 3'b000} +: 8] : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-wide behavioural memory
// and a scoreboard of expected responses.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [0:255];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    else if (pre_we)         mem[pre_addr] <= pre_data;
  end

  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  int we_cnt = 0;
  always @(negedge clk) if (bus.mem_we === 1'b1) we_cnt++;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwe;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic drive_idle();
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input string name);
    exp_t e;
    int   lat;
    int   we0;
    e.rdata = er;
    e.err   = ee;
    e.lat   = ee ? 1 : (sz == 2'b00 ? 2 : (sz == 2'b01 ? 3 : 5));
    e.nwe   = (ee || !w) ? 0 : e.lat - 1;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    lat = 0;
    while (bus.req_ready !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL %s ready: got %b want 1", name, bus.req_ready);
    end
    we0 = we_cnt;
    @(posedge clk);
    @(negedge clk);
    // Scramble the request fields to show the transaction no longer depends on them.
    bus.req_valid = 1'b0; bus.req_write = ~w; bus.req_size = ~sz;
    bus.req_signed = ~sg; bus.req_addr = ~a; bus.req_wdata = ~wd;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 12) begin @(negedge clk); lat++; end
    e = sb.pop_front();
    total++;
    if (bus.resp_valid !== 1'b1) begin
      bad++; $display("FAIL %s resp_timeout: resp_valid=%b want 1", name, bus.resp_valid);
    end
    total++;
    if (lat != e.lat) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
    end
    total++;
    if (bus.resp_rdata !== e.rdata) begin
      bad++; $display("FAIL %s rdata: got %h want %h", name, bus.resp_rdata, e.rdata);
    end
    total++;
    if (bus.resp_err !== e.err) begin
      bad++; $display("FAIL %s err: got %b want %b", name, bus.resp_err, e.err);
    end
    total++;
    if (we_cnt - we0 != e.nwe) begin
      bad++; $display("FAIL %s we_cycles: got %0d want %0d", name, we_cnt - we0, e.nwe);
    end
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL %s resp_pulse: resp_valid=%b want 0", name, bus.resp_valid);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 ||
        bus.resp_rdata !== 32'h0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 ||
        bus.mem_wdata !== 8'h0) begin
      bad++;
      $display("FAIL %s: ready=%b rv=%b err=%b rdata=%h we=%b addr=%h wdata=%h want 1 0 0 0 0 0 0",
               name, bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata,
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic check_mem(input logic [7:0] a, input logic [7:0] want, input string name);
    total++;
    if (mem[a] !== want) begin
      bad++; $display("FAIL %s mem[%h]: got %h want %h", name, a, mem[a], want);
    end
  endtask

  task automatic test_reset();
    logic [7:0] init [0:3];
    init[0] = 8'h80; init[1] = 8'h01; init[2] = 8'h02; init[3] = 8'h03;
    drive_idle();
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 8'(i);
      pre_data = (i >= 16 && i < 20) ? init[i-16] : 8'h00;
    end
    @(negedge clk);
    pre_we = 1'b0;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80010203, 1'b0, "ld_word");
    do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'hFFFFFF80, 1'b0, "ld_byte_s");
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h00008001, 1'b0, "ld_half_u");
    do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h00000080, 1'b0, "ld_byte_u");
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'hFFFF8001, 1'b0, "ld_half_s");
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00000203, 1'b0, "ld_half_s_pos");
    do_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h80010203, 1'b0, "ld_word_s");
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000003, 1'b0, "ld_byte_s_pos");
  endtask

  task automatic test_stores();
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, "st_word");
    check_mem(8'h20, 8'hDE, "st_word"); check_mem(8'h21, 8'hAD, "st_word");
    check_mem(8'h22, 8'hBE, "st_word"); check_mem(8'h23, 8'hEF, "st_word");
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, "ld_back");
    do_req(1'b1, 2'b01, 1'b0, 32'h24, 32'h1234ABCD, 32'h0, 1'b0, "st_half");
    check_mem(8'h24, 8'hAB, "st_half"); check_mem(8'h25, 8'hCD, "st_half");
    do_req(1'b1, 2'b00, 1'b0, 32'h27, 32'h99887755, 32'h0, 1'b0, "st_byte");
    check_mem(8'h27, 8'h55, "st_byte"); check_mem(8'h26, 8'h00, "st_byte_nb");
    do_req(1'b0, 2'b01, 1'b1, 32'h24, 32'h0, 32'hFFFFABCD, 1'b0, "ld_half_back");
  endtask

  task automatic test_errors();
    do_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, "err_word");
    do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1, "err_half");
    do_req(1'b0, 2'b11, 1'b0, 32'h0,  32'h0, 32'h0, 1'b1, "err_size");
    do_req(1'b1, 2'b10, 1'b0, 32'h31, 32'hCAFEF00D, 32'h0, 1'b1, "err_st_word");
    check_mem(8'h31, 8'h00, "err_st_word");
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 32'h30; bus.req_wdata = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.resp_valid !== 1'b0 || bus.mem_we !== 1'b0) begin
        bad++; $display("FAIL abort_quiet: rv=%b we=%b want 0 0", bus.resp_valid, bus.mem_we);
      end
    end
    check_mem(8'h30, 8'h11, "abort");
    total++;
    if (mem[8'h31] !== 8'h00 && mem[8'h31] !== 8'h22) begin
      bad++; $display("FAIL abort mem[31]: got %h want 00 or 22", mem[8'h31]);
    end
    check_mem(8'h32, 8'h00, "abort"); check_mem(8'h33, 8'h00, "abort");
    rst_n = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80010203, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    e.err = 1'b0; e.lat = 2; e.nwe = 0;
    e.rdata = 32'hFFFFFF80; sb.push_back(e);
    e.rdata = 32'h00000001; sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b1; bus.req_addr = 32'h10; bus.req_wdata = '0;
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL b2b ready0: got %b want 1", bus.req_ready); end
    @(posedge clk);
    @(negedge clk);
    bus.req_signed = 1'b0; bus.req_addr = 32'h11;
    total++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL b2b xfer1: ready=%b rv=%b want 0 0", bus.req_ready, bus.resp_valid);
    end
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_rdata !== e.rdata) begin
      bad++; $display("FAIL b2b resp1: ready=%b rv=%b rdata=%h want 0 1 %h",
                      bus.req_ready, bus.resp_valid, bus.resp_rdata, e.rdata);
    end
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL b2b idle: ready=%b rv=%b want 1 0", bus.req_ready, bus.resp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    total++;
    if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL b2b xfer2: ready=%b want 0", bus.req_ready); end
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_rdata !== e.rdata) begin
      bad++; $display("FAIL b2b resp2: ready=%b rv=%b rdata=%h want 0 1 %h",
                      bus.req_ready, bus.resp_valid, bus.resp_rdata, e.rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of the byte address.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  processor presents a load/store request.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_write  input  1  1=store, 0=load.
REQ-007 SHALL have port req_size  input  2  00=byte, 01=halfword, 10=word, 11=illegal.
REQ-008 SHALL have port req_signed  input  1  sign-extend load result when 1; zero-extend when 0.
REQ-009 SHALL have port req_addr  input  ADDR_W  byte address, the ALU result.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  misaligned or illegal-size request, valid with resp_valid.
REQ-014 SHALL have port mem_addr  output  ADDR_W  byte address to byte-wide data memory.
REQ-015 SHALL have port mem_wdata  output  8  byte to write.
REQ-016 SHALL have port mem_we  output  1  write strobe; memory writes mem_wdata at mem_addr on rising clk when 1.
REQ-017 SHALL have port mem_rdata  input  8  byte at mem_addr, combinational (asynchronous read).

Function
REQ-018 SHALL implement FSM states IDLE, XFER, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1, and all req_* fields are captured at that edge.
REQ-020 On acceptance, byte count N SHALL be 1/2/4 for size 00/01/10.
REQ-021 Requests with size 11, or with addr[0]!=0 (half) or addr[1:0]!=0 (word), SHALL go IDLE->RESP with resp_err=1 and no memory access (mem_we stays 0).
REQ-022 Legal requests SHALL go IDLE->XFER; XFER SHALL last exactly N cycles, byte counter i=0..N-1, mem_addr=captured addr+i.
REQ-023 Byte order SHALL be big-endian: byte i carries bits [8*(N-1-i)+7 : 8*(N-1-i)] of the N-byte value.
REQ-024 Stores SHALL drive mem_we=1 and mem_wdata=byte i in each XFER cycle; loads SHALL drive mem_we=0 and shift mem_rdata into an assembly register each XFER cycle.
REQ-025 After the last XFER cycle the FSM SHALL enter RESP for exactly one cycle with resp_valid=1, then return to IDLE.
REQ-026 Load result SHALL be the N assembled bytes, extended to 32 bits per captured req_signed; word loads ignore req_signed.
REQ-027 Latency: acceptance edge to resp_valid = N+1 cycles for legal requests, 1 cycle for errors; next acceptance no earlier than the cycle after RESP.
REQ-028 Outside XFER, mem_we SHALL be 0, mem_addr SHALL equal captured address, mem_wdata SHALL be 0.
REQ-029 Address arithmetic addr+i SHALL wrap modulo 2^ADDR_W.
REQ-030 req_* changes after acceptance SHALL NOT affect the transaction in progress.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, counter 0, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, independent of clk.
REQ-032 Reset mid-XFER SHALL abort the transaction with no further mem_we and no resp_valid; bytes already written remain written.
REQ-033 After rst_n rises, the first request SHALL be acceptable on the first rising edge.

Verification
REQ-034 Memory 0x10..0x13 = 80 01 02 03; load word addr 0x10 -> resp_valid 5 cycles after accept, resp_rdata=0x80010203, resp_err=0.
REQ-035 Same memory; load byte signed 0x10 -> 0xFFFFFF80 after 2 cycles; load half unsigned 0x10 -> 0x00008001 after 3 cycles.
REQ-036 Store word 0xDEADBEEF at 0x20 -> mem_we high 4 cycles, bytes DE AD BE EF at 0x20..0x23, resp_rdata=0; then load word 0x20 -> 0xDEADBEEF.
REQ-037 Load word at 0x22, load half at 0x21, size 11 at 0x0 -> each resp_valid after 1 cycle with resp_err=1, mem_we never asserted.
REQ-038 Store word 0x11223344 at 0x30, rst_n low during second XFER cycle -> outputs at reset values immediately, only 0x30 (0x11) and possibly 0x31 written, no resp_valid; next request accepted normally.
REQ-039 Back-to-back: req_valid held high with two byte loads -> second accepted the cycle after first RESP, req_ready low throughout XFER/RESP.
